// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the wishbone-port side and controller side of the SDRAM port arbiter.
// slave is the arbiter's view; master is the view of whatever drives the ports and controller.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    acc_i;
    logic [NUM_PORTS-1:0]    we_i;
    logic [32*NUM_PORTS-1:0] adr_i;
    logic [16*NUM_PORTS-1:0] dat_i;
    logic [2*NUM_PORTS-1:0]  sel_i;
    logic [NUM_PORTS-1:0]    ack_o;
    logic [15:0]             dat_o;
    logic [NUM_PORTS-1:0]    grant_o;

    logic        ctrl_acc_o;
    logic        ctrl_we_o;
    logic [31:0] ctrl_adr_o;
    logic [15:0] ctrl_dat_o;
    logic [1:0]  ctrl_sel_o;
    logic        ctrl_ack_i;
    logic [15:0] ctrl_dat_i;

    modport slave (
        input  acc_i, we_i, adr_i, dat_i, sel_i, ctrl_ack_i, ctrl_dat_i,
        output ack_o, dat_o, grant_o, ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o
    );

    modport master (
        output acc_i, we_i, adr_i, dat_i, sel_i, ctrl_ack_i, ctrl_dat_i,
        input  ack_o, dat_o, grant_o, ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Grants the SDRAM controller's access interface to one wishbone port at a time, holding the
// grant across short refill gaps. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module sdram_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_rst,
    sdram_port_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_PORTS - 1);
    localparam logic [3:0]       HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             winner_found;
    logic [IDX_W-1:0] winner;
    logic             owner_req;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!winner_found && bus.acc_i[(int'(last_q) + i) % NUM_PORTS]) begin
                winner_found = 1'b1;
                winner       = IDX_W'((int'(last_q) + i) % NUM_PORTS);
            end
        end
`else
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!winner_found && bus.acc_i[i]) begin
                winner_found = 1'b1;
                winner       = IDX_W'(i);
            end
        end
`endif
    end

    assign owner_req = bus.acc_i[grant_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_d = winner;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (!owner_req) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Owner reassertion resumes without rearbitration; others wait for IDLE.
                if (owner_req) begin
                    state_d = GRANTED;
                end else if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forwarding is combinational from the registered grant, so reassertion in HOLD costs no cycle.
    always_comb begin
        bus.ctrl_acc_o = 1'b0;
        bus.ctrl_we_o  = 1'b0;
        bus.ctrl_adr_o = '0;
        bus.ctrl_dat_o = '0;
        bus.ctrl_sel_o = '0;
        bus.ack_o      = '0;
        bus.grant_o    = '0;
        bus.dat_o      = bus.ctrl_dat_i;
        if (state_q != IDLE) begin
            bus.ctrl_acc_o       = owner_req;
            bus.ctrl_we_o        = bus.we_i[grant_q];
            bus.ctrl_adr_o       = bus.adr_i[32*int'(grant_q) +: 32];
            bus.ctrl_dat_o       = bus.dat_i[16*int'(grant_q) +: 16];
            bus.ctrl_sel_o       = bus.sel_i[2*int'(grant_q) +: 2];
            bus.ack_o[grant_q]   = bus.ctrl_ack_i;
            bus.grant_o[grant_q] = 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized and directed bench for sdram_port_arbiter: two instances (HOLD_CYCLES 4 and 0) share
// stimulus and are compared against an ownership model built from idle-run counts.
module tb_sdram_port_arbiter;
    localparam int NP = 2;

    typedef struct packed {
        logic [NP-1:0] grant;
        logic [NP-1:0] ack;
        logic          acc;
        logic          we;
        logic [31:0]   adr;
        logic [15:0]   dat;
        logic [1:0]    sel;
        logic [15:0]   rdat;
    } out_t;

    logic sdram_clk;
    logic sdram_rst;

    logic [NP-1:0] acc, we;
    logic [31:0]   adr [NP];
    logic [15:0]   wdat[NP];
    logic [1:0]    sel [NP];
    logic          cack;
    logic [15:0]   cdat;

    logic [32*NP-1:0] adr_flat;
    logic [16*NP-1:0] dat_flat;
    logic [2*NP-1:0]  sel_flat;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: owner (-1 idle), consecutive non-requesting owner cycles, last owner.
    int owner   [2];
    int idle_run[2];
    int last_own[2];
    int hold_of [2];

    sdram_port_arbiter_if #(.NUM_PORTS(NP)) bus4 ();
    sdram_port_arbiter_if #(.NUM_PORTS(NP)) bus0 ();

    sdram_port_arbiter #(.NUM_PORTS(NP), .HOLD_CYCLES(4)) dut4 (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .bus       (bus4.slave)
    );
    sdram_port_arbiter #(.NUM_PORTS(NP), .HOLD_CYCLES(0)) dut0 (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .bus       (bus0.slave)
    );

    always_comb begin
        adr_flat = '0;
        dat_flat = '0;
        sel_flat = '0;
        for (int p = 0; p < NP; p++) begin
            adr_flat[32*p +: 32] = adr[p];
            dat_flat[16*p +: 16] = wdat[p];
            sel_flat[2*p +: 2]   = sel[p];
        end
    end

    assign bus4.acc_i = acc;      assign bus0.acc_i = acc;
    assign bus4.we_i = we;        assign bus0.we_i = we;
    assign bus4.adr_i = adr_flat; assign bus0.adr_i = adr_flat;
    assign bus4.dat_i = dat_flat; assign bus0.dat_i = dat_flat;
    assign bus4.sel_i = sel_flat; assign bus0.sel_i = sel_flat;
    assign bus4.ctrl_ack_i = cack; assign bus0.ctrl_ack_i = cack;
    assign bus4.ctrl_dat_i = cdat; assign bus0.ctrl_dat_i = cdat;

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    function automatic int pick(int k);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= NP; i++)
            if (acc[(last_own[k] + i) % NP]) return (last_own[k] + i) % NP;
`else
        for (int i = 0; i < NP; i++)
            if (acc[i]) return i;
`endif
        return -1;
    endfunction

    function automatic void model_update();
        for (int k = 0; k < 2; k++) begin
            if (sdram_rst) begin
                owner[k] = -1; idle_run[k] = 0; last_own[k] = NP - 1;
            end else if (owner[k] < 0) begin
                owner[k] = pick(k); idle_run[k] = 0;
            end else if (acc[owner[k]]) begin
                idle_run[k] = 0;
            end else begin
                idle_run[k]++;
                if (idle_run[k] > hold_of[k]) begin
                    last_own[k] = owner[k]; owner[k] = -1;
                end
            end
        end
    endfunction

    function automatic out_t exp_out(int k);
        out_t o = '0;
        int g   = owner[k];
        o.rdat = cdat;
        if (g >= 0) begin
            o.grant = NP'(1) << g;
            o.ack   = cack ? (NP'(1) << g) : '0;
            o.acc   = acc[g];
            o.we    = we[g];
            o.adr   = adr[g];
            o.dat   = wdat[g];
            o.sel   = sel[g];
        end
        return o;
    endfunction

    function automatic out_t act_out(int k);
        out_t o;
        if (k == 0) o = '{bus4.grant_o, bus4.ack_o, bus4.ctrl_acc_o, bus4.ctrl_we_o,
                          bus4.ctrl_adr_o, bus4.ctrl_dat_o, bus4.ctrl_sel_o, bus4.dat_o};
        else        o = '{bus0.grant_o, bus0.ack_o, bus0.ctrl_acc_o, bus0.ctrl_we_o,
                          bus0.ctrl_adr_o, bus0.ctrl_dat_o, bus0.ctrl_sel_o, bus0.dat_o};
        return o;
    endfunction

    // Model advances on the same edge the DUTs sample; inputs change at the falling edge.
    task automatic tick();
        @(posedge sdram_clk);
        model_update();
        @(negedge sdram_clk);
    endtask

    task automatic set_port(int p, logic a, logic w, logic [31:0] ad);
        acc[p] = a; we[p] = w; adr[p] = ad;
        wdat[p] = 16'(ad) ^ 16'h5A5A; sel[p] = 2'b11;
    endtask

    task automatic test_reset();
        sdram_rst = 1'b1; acc = '0; cack = 1'b1; cdat = 16'h1234;
        tick();
        sdram_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (act_out(k) !== exp_out(k)) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: got %h want %h", k, act_out(k), exp_out(k));
            end
        end
        tests_run++;
        if (bus4.grant_o !== '0 || bus4.ack_o !== '0 || bus4.ctrl_acc_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_zero: grant %b ack %b acc %b want 0", bus4.grant_o, bus4.ack_o, bus4.ctrl_acc_o);
        end
        cack = 1'b0;
    endtask

    task automatic test_single_write();
        logic [NP-1:0] g_seen [8];
        set_port(0, 1'b1, 1'b1, 32'h100);
        #1;
        tests_run++;
        if (bus4.ctrl_acc_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency0: ctrl_acc %b want 0", bus4.ctrl_acc_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            cack = (c == 2);
            #1;
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (act_out(k) !== exp_out(k)) begin
                    tests_failed++;
                    $display("FAIL single_access c%0d dut%0d: got %h want %h", c, k, act_out(k), exp_out(k));
                end
            end
        end
        tests_run++;
        if (bus4.ctrl_adr_o !== 32'h100 || bus4.ack_o !== 2'b01 || bus4.ctrl_acc_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_fields: adr %h ack %b acc %b want 100 01 1",
                     bus4.ctrl_adr_o, bus4.ack_o, bus4.ctrl_acc_o);
        end
        tick();
        cack = 1'b0; acc[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            g_seen[c] = bus4.grant_o;
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (act_out(k) !== exp_out(k)) begin
                    tests_failed++;
                    $display("FAIL single_release c%0d dut%0d: got %h want %h", c, k, act_out(k), exp_out(k));
                end
            end
        end
        tests_run++;
        if (g_seen[3] !== 2'b01 || g_seen[4] !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_hold_len: grant after 4 %b after 5 %b want 01 00", g_seen[3], g_seen[4]);
        end
    endtask

    task automatic test_refill_gap();
        int waited;
        // port 1 owns, port 0 requests throughout
        set_port(1, 1'b1, 1'b0, 32'h2000);
        tick();
        set_port(0, 1'b1, 1'b0, 32'h3000);
        for (int c = 0; c < 9; c++) begin
            acc[1] = !(c >= 2 && c < 5);
            #1;
            tests_run++;
            if (bus4.grant_o !== 2'b10) begin
                tests_failed++;
                $display("FAIL refill_hold c%0d: grant %b want 10", c, bus4.grant_o);
            end
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (act_out(k) !== exp_out(k)) begin
                    tests_failed++;
                    $display("FAIL refill_model c%0d dut%0d: got %h want %h", c, k, act_out(k), exp_out(k));
                end
            end
            tick();
        end
        acc[1] = 1'b0;
        waited = 0;
        while (bus4.grant_o !== 2'b01 && waited < 20) begin
            tick();
            waited++;
            #1;
        end
        tests_run++;
        if (waited != 6) begin
            tests_failed++;
            $display("FAIL refill_handover: port0 granted after %0d cycles want 6", waited);
        end
        acc = '0;
    endtask

    task automatic test_simultaneous();
        logic [NP-1:0] want;
        sdram_rst = 1'b1; acc = '0;
        tick();
        sdram_rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            set_port(0, 1'b1, 1'b1, 32'h40 + 32'(r));
            set_port(1, 1'b1, 1'b0, 32'h80 + 32'(r));
            tick();
            acc = '0;
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            want = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
            want = 2'b01;
`endif
            tests_run++;
            if (bus4.grant_o !== want || bus0.grant_o !== want) begin
                tests_failed++;
                $display("FAIL simul_round%0d: grants %b/%b want %b", r, bus4.grant_o, bus0.grant_o, want);
            end
            for (int c = 0; c < 20 && (owner[0] >= 0 || owner[1] >= 0); c++) tick();
            #1;
            tests_run++;
            if (bus4.grant_o !== '0 || bus0.grant_o !== '0) begin
                tests_failed++;
                $display("FAIL simul_idle%0d: grants %b/%b want 00", r, bus4.grant_o, bus0.grant_o);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        set_port(0, 1'b1, 1'b1, 32'hA0);
        tick();
        tick();
        #1;
        tests_run++;
        if (bus4.ctrl_acc_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: ctrl_acc %b want 1", bus4.ctrl_acc_o);
        end
        sdram_rst = 1'b1;
        tick();
        sdram_rst = 1'b0; acc = '0;
        #1;
        tests_run++;
        if (bus4.ctrl_acc_o !== 1'b0 || bus4.ack_o !== '0 || bus4.grant_o !== '0 ||
            bus0.ctrl_acc_o !== 1'b0 || bus0.grant_o !== '0) begin
            tests_failed++;
            $display("FAIL midrst_post: acc %b ack %b grant %b want 0 00 00",
                     bus4.ctrl_acc_o, bus4.ack_o, bus4.grant_o);
        end
        cack = 1'b1;
        #1;
        tests_run++;
        if (bus4.ack_o !== '0 || bus0.ack_o !== '0) begin
            tests_failed++;
            $display("FAIL stray_ack: ack %b/%b want 00", bus4.ack_o, bus0.ack_o);
        end
        cack = 1'b0;
        tick();
    endtask

    task automatic test_read_data();
        cdat = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            acc = NP'(c < 4 ? 1 : 0);
            #1;
            tests_run++;
            if (bus4.dat_o !== 16'hBEEF || bus0.dat_o !== 16'hBEEF) begin
                tests_failed++;
                $display("FAIL read_data c%0d: dat_o %h/%h want beef", c, bus4.dat_o, bus0.dat_o);
            end
            tick();
        end
        acc = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            sdram_rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NP; p++) begin
                // sticky requests so gaps shorter and longer than the hold window both occur
                if ($urandom_range(0, 3) == 0) acc[p] = ~acc[p];
                we[p] = 1'($urandom); adr[p] = $urandom;
                wdat[p] = 16'($urandom); sel[p] = 2'($urandom);
            end
            cack = 1'($urandom);
            cdat = 16'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (act_out(k) !== exp_out(k)) begin
                    tests_failed++;
                    $display("FAIL random c%0d dut%0d: got %h want %h", c, k, act_out(k), exp_out(k));
                end
            end
            tick();
        end
        sdram_rst = 1'b0; acc = '0; cack = 1'b0;
    endtask

    initial begin
        hold_of[0] = 4; hold_of[1] = 0;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; idle_run[k] = 0; last_own[k] = NP - 1;
        end
        sdram_rst = 1'b1; acc = '0; we = '0; cack = 1'b0; cdat = '0;
        for (int p = 0; p < NP; p++) begin
            adr[p] = '0; wdat[p] = '0; sel[p] = '0;
        end
        @(negedge sdram_clk);
        test_reset();
        test_single_write();
        test_refill_gap();
        test_simultaneous();
        test_reset_mid_access();
        test_read_data();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
